// File: rtl/regfile_dec_param.sv
// rtl/regfile_dec_param.sv - parametrised register file with N-to-2^N write decoder
//
// Purpose:
//   MIPS-style register file. It has two combinational read ports and one
//   synchronous write port. The write strobe comes from a generalised
//   ADDR_W-to-2^ADDR_W decoder. The design supports an optional hardwired-zero
//   register 0 and optional write-through bypass. It also keeps a registered
//   one-hot copy of the last accepted strobe and a saturating write counter.
//
// Ports:
//   Clk       in   1       clock, rising edge
//   Rst_n     in   1       asynchronous active-low reset
//   WrEn      in   1       write enable
//   Awr       in   ADDR_W  write address
//   Din       in   DATA_W  write data
//   Ard1      in   ADDR_W  read address, port 1
//   Ard2      in   ADDR_W  read address, port 2
//   Dout1     out  DATA_W  read data, port 1 (combinational)
//   Dout2     out  DATA_W  read data, port 2 (combinational)
//   WrOneHot  out  NREG    registered accepted-write strobe
//   WrCnt     out  16      saturating count of accepted writes

module regfile_dec_param #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    WrEn,
  input  logic [ADDR_W-1:0]       Awr,
  input  logic [DATA_W-1:0]       Din,
  input  logic [ADDR_W-1:0]       Ard1,
  input  logic [ADDR_W-1:0]       Ard2,
  output logic [DATA_W-1:0]       Dout1,
  output logic [DATA_W-1:0]       Dout2,
  output logic [(1<<ADDR_W)-1:0]  WrOneHot,
  output logic [15:0]             WrCnt
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0]   strobe;
  logic [NREG-1:0]   accept;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   onehot_q, onehot_d;
  logic [15:0]       cnt_q, cnt_d;

  // Write decoder. Accepted strobes are masked by Rst_n so that the bypass
  // path cannot leak Din onto the read ports while reset is held.
  always_comb begin
    strobe = '0;
    for (int i = 0; i < NREG; i++) begin
      strobe[i] = WrEn && (Awr == ADDR_W'(i));
    end
    accept = strobe & {NREG{Rst_n}};
    if (ZERO_REG != 0) begin
      accept[0] = 1'b0;
    end
  end

  always_comb begin
    onehot_d = accept;
    cnt_d    = cnt_q;
    if ((|accept) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      onehot_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (accept[i]) begin
          regs_q[i] <= Din;
        end
      end
      onehot_q <= onehot_d;
      cnt_q    <= cnt_d;
    end
  end

  // Read port mux. The order is zero register, then bypass, then storage.
  // Under ZERO_REG=1, accept[0] is never set, so a read of r0 gives 0 even
  // without the first test. The first test keeps that case explicit.
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = regs_q[a];
    if ((ZERO_REG != 0) && (a == '0)) begin
      v = '0;
    end else if ((BYPASS != 0) && accept[a]) begin
      v = Din;
    end
    return v;
  endfunction

  assign Dout1    = rd(Ard1);
  assign Dout2    = rd(Ard2);
  assign WrOneHot = onehot_q;
  assign WrCnt    = cnt_q;

endmodule

// File: tb/tb_regfile_dec_param.sv
// tb/tb_regfile_dec_param.sv - directed testbench for regfile_dec_param

module tb_regfile_dec_param;

  logic Clk;
  logic Rst_n;

  // default instance: ADDR_W=5, DATA_W=32, ZERO_REG=1, BYPASS=1
  logic        d_wren;
  logic [4:0]  d_awr, d_ard1, d_ard2;
  logic [31:0] d_din, d_dout1, d_dout2, d_onehot;
  logic [15:0] d_cnt;

  // no-bypass instance
  logic        n_wren;
  logic [4:0]  n_awr, n_ard1, n_ard2;
  logic [31:0] n_din, n_dout1, n_dout2, n_onehot;
  logic [15:0] n_cnt;

  // small instance: ADDR_W=3, DATA_W=8, ZERO_REG=0
  logic        s_wren;
  logic [2:0]  s_awr, s_ard1, s_ard2;
  logic [7:0]  s_din, s_dout1, s_dout2, s_onehot;
  logic [15:0] s_cnt;

  int n_cmp;
  int n_err;

  regfile_dec_param u_def (
    .Clk(Clk), .Rst_n(Rst_n), .WrEn(d_wren), .Awr(d_awr), .Din(d_din),
    .Ard1(d_ard1), .Ard2(d_ard2), .Dout1(d_dout1), .Dout2(d_dout2),
    .WrOneHot(d_onehot), .WrCnt(d_cnt)
  );

  regfile_dec_param #(.BYPASS(0)) u_nb (
    .Clk(Clk), .Rst_n(Rst_n), .WrEn(n_wren), .Awr(n_awr), .Din(n_din),
    .Ard1(n_ard1), .Ard2(n_ard2), .Dout1(n_dout1), .Dout2(n_dout2),
    .WrOneHot(n_onehot), .WrCnt(n_cnt)
  );

  regfile_dec_param #(.ADDR_W(3), .DATA_W(8), .ZERO_REG(0)) u_sm (
    .Clk(Clk), .Rst_n(Rst_n), .WrEn(s_wren), .Awr(s_awr), .Din(s_din),
    .Ard1(s_ard1), .Ard2(s_ard2), .Dout1(s_dout1), .Dout2(s_dout2),
    .WrOneHot(s_onehot), .WrCnt(s_cnt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    Rst_n = 1'b0;
    d_wren = 0; d_awr = 0; d_din = 0; d_ard1 = 0; d_ard2 = 0;
    n_wren = 0; n_awr = 0; n_din = 0; n_ard1 = 0; n_ard2 = 0;
    s_wren = 0; s_awr = 0; s_din = 0; s_ard1 = 0; s_ard2 = 0;

    // 1. reset with random read addresses
    d_ard1 = 5'($urandom);
    d_ard2 = 5'($urandom);
    tick();
    tick();
    check("rst_dout1", d_dout1, 0);
    check("rst_dout2", d_dout2, 0);
    check("rst_onehot", d_onehot, 0);
    check("rst_cnt", d_cnt, 0);
    Rst_n = 1'b1;
    tick();
    for (int a = 0; a < 32; a++) begin
      d_ard1 = 5'(a);
      #1;
      check($sformatf("rst_sweep_r%0d", a), d_dout1, 0);
    end

    // 2. decoder sweep
    for (int k = 0; k < 32; k++) begin
      d_wren = 1'b1;
      d_awr  = 5'(k);
      d_din  = 32'hA5A50000 + 32'(k);
      tick();
      check($sformatf("onehot_k%0d", k), d_onehot, (k == 0) ? 64'd0 : (64'd1 << k));
    end
    d_wren = 1'b0;
    tick();
    check("sweep_cnt", d_cnt, 31);
    check("sweep_onehot_idle", d_onehot, 0);
    for (int k = 0; k < 32; k++) begin
      d_ard1 = 5'(k);
      #1;
      check($sformatf("readback_r%0d", k), d_dout1, (k == 0) ? 64'd0 : 64'hA5A50000 + 64'(k));
    end

    // 3. bypass versus no bypass on r7
    d_wren = 1; d_awr = 7; d_din = 32'h1111;
    n_wren = 1; n_awr = 7; n_din = 32'h1111;
    tick();
    d_din = 32'h2222; d_ard1 = 7;
    n_din = 32'h2222; n_ard1 = 7;
    #1;
    check("bypass_pre_edge", d_dout1, 32'h2222);
    check("nobypass_pre_edge", n_dout1, 32'h1111);
    tick();
    check("nobypass_post_edge", n_dout1, 32'h2222);
    d_wren = 0; n_wren = 0;
    #1;
    check("bypass_stored", d_dout1, 32'h2222);
    check("nobypass_cnt", n_cnt, 2);

    // 4. WrEn gating
    d_awr = 3; d_din = 32'hFFFFFFFF; d_ard1 = 3;
    repeat (5) tick();
    check("gate_r3", d_dout1, 32'hA5A50003);
    check("gate_onehot", d_onehot, 0);
    check("gate_cnt", d_cnt, 33);

    // 5. async reset mid-operation
    d_wren = 1; d_awr = 9; d_din = 32'hDEADBEEF;
    tick();
    d_wren = 0; d_ard1 = 9;
    #1;
    check("pre_async_r9", d_dout1, 32'hDEADBEEF);
    check("pre_async_cnt", d_cnt, 34);
    Rst_n = 1'b0;
    #1;
    check("async_r9", d_dout1, 0);
    check("async_cnt", d_cnt, 0);
    #2;
    Rst_n = 1'b1;
    tick();
    check("post_async_r9", d_dout1, 0);
    check("post_async_cnt", d_cnt, 0);

    // 6. parameter corners: r0 is ordinary, then counter saturation
    s_wren = 1; s_awr = 0; s_din = 8'h5A; s_ard2 = 0;
    tick();
    s_wren = 0;
    #1;
    check("sm_r0", s_dout2, 8'h5A);
    check("sm_onehot", s_onehot, 8'h01);
    check("sm_cnt1", s_cnt, 1);
    s_wren = 1;
    for (int i = 0; i < 65533; i++) begin
      s_awr = 3'(i);
      s_din = 8'(i);
      tick();
    end
    check("sm_cnt_fffe", s_cnt, 16'hFFFE);
    tick();
    check("sm_cnt_ffff", s_cnt, 16'hFFFF);
    repeat (5) tick();
    check("sm_cnt_sat", s_cnt, 16'hFFFF);
    s_wren = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
